// File: rtl/wb_ram_slave.sv
// ---------------------------------------------------------------------------
// wb_ram_slave
//
// Wishbone classic single-port RAM slave. Each accepted request is latched,
// delayed by WAIT_STATES cycles, then terminated by exactly one of
// ack_o / err_o / rty_o for a single cycle. Writes honour byte selects.
// Out-of-range or misaligned addresses terminate with err_o. An external
// hold signal forces rty_o unless the request was made under lock.
//
// Ports
//   clk_i   : clock, all state on the rising edge
//   rst_i   : asynchronous active-low reset
//   adr_i   : byte address
//   dat_i   : write data
//   dat_o   : read data, holds the last acked read value
//   sel_i   : byte enables, bit n covers dat[8n+7:8n]
//   we_i    : 1 = write, 0 = read
//   cyc_i   : bus cycle active; dropping it while waiting aborts the request
//   stb_i   : transfer strobe
//   lock_i  : locked sequence, suppresses retry
//   hold_i  : memory busy, forces rty_o when the request is not locked
//   ack_o   : normal termination pulse
//   err_o   : error termination pulse
//   rty_o   : retry termination pulse
// ---------------------------------------------------------------------------
module wb_ram_slave #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    SEL_WIDTH   = 4,
    parameter int                    DEPTH_WORDS = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h0000_0000,
    parameter int                    WAIT_STATES = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] adr_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic [DATA_WIDTH-1:0] dat_o,
    input  logic [SEL_WIDTH-1:0]  sel_i,
    input  logic                  we_i,
    input  logic                  cyc_i,
    input  logic                  stb_i,
    input  logic                  lock_i,
    input  logic                  hold_i,
    output logic                  ack_o,
    output logic                  err_o,
    output logic                  rty_o
);

    localparam int         IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WS    = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    accept;
    logic                    eval;

    // Latched request
    logic [ADDR_WIDTH-1:0]   adr_q;
    logic [DATA_WIDTH-1:0]   dat_q;
    logic [SEL_WIDTH-1:0]    sel_q;
    logic                    we_q;
    logic                    lock_q;

    // Request as seen by the evaluation: straight from the bus when
    // WAIT_STATES is zero (evaluation happens on the accepting edge),
    // otherwise from the latched copy.
    logic [ADDR_WIDTH-1:0]   e_adr;
    logic [DATA_WIDTH-1:0]   e_dat;
    logic [SEL_WIDTH-1:0]    e_sel;
    logic                    e_we;
    logic                    e_lock;

    logic                    bad_addr;
    logic                    rty_hit;
    logic                    ack_hit;
    logic                    mem_we;
    logic                    mem_rd;
    logic [IDX_W-1:0]        idx;

    logic [DATA_WIDTH-1:0]   mem [DEPTH_WORDS];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every signal gets a default at the top of the always_comb so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        eval    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (cyc_i && stb_i) begin
                    accept = 1'b1;
                    cnt_d  = WS;
                    if (WS == 4'd0) begin
                        eval    = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!cyc_i) begin
                    // Master abandoned the cycle: no write, no response.
                    cnt_d   = 4'd0;
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd1) begin
                    eval    = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Evaluation: err beats rty beats ack
    // ------------------------------------------------------------------
    always_comb begin
        if (state_q == S_IDLE) begin
            e_adr  = adr_i;
            e_dat  = dat_i;
            e_sel  = sel_i;
            e_we   = we_i;
            e_lock = lock_i;
        end else begin
            e_adr  = adr_q;
            e_dat  = dat_q;
            e_sel  = sel_q;
            e_we   = we_q;
            e_lock = lock_q;
        end
    end

    // BASE_ADDR is aligned to the RAM size, so the range check reduces to a
    // compare of the bits above the word index, and the word index is just
    // the address bits below them.
    assign bad_addr = (|e_adr[1:0]) ||
                      (e_adr[ADDR_WIDTH-1:IDX_W+2] != BASE_ADDR[ADDR_WIDTH-1:IDX_W+2]);
    assign rty_hit  = !bad_addr && hold_i && !e_lock;
    assign ack_hit  = !bad_addr && !rty_hit;
    assign idx      = e_adr[IDX_W+1:2];
    // Gated by rst_i so an edge seen while reset is held cannot commit.
    assign mem_we   = rst_i && eval && ack_hit && e_we;
    assign mem_rd   = eval && ack_hit && !e_we;

    // ------------------------------------------------------------------
    // State, request and response registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            lock_q  <= 1'b0;
            ack_o   <= 1'b0;
            err_o   <= 1'b0;
            rty_o   <= 1'b0;
            dat_o   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                adr_q  <= adr_i;
                dat_q  <= dat_i;
                sel_q  <= sel_i;
                we_q   <= we_i;
                lock_q <= lock_i;
            end
            // Pulses are re-evaluated every edge, so they last one cycle.
            ack_o <= eval && ack_hit;
            err_o <= eval && bad_addr;
            rty_o <= eval && rty_hit;
            if (mem_rd) begin
                dat_o <= mem[idx];
            end
        end
    end

    // ------------------------------------------------------------------
    // RAM array with byte-lane writes
    // ------------------------------------------------------------------
    // NOTE: the array has no reset; contents survive rst_i and the block maps
    // onto plain RAM.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < SEL_WIDTH; b++) begin
                if (e_sel[b]) begin
                    mem[idx][8*b +: 8] <= e_dat[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_ram_slave.sv
// ---------------------------------------------------------------------------
// tb_wb_ram_slave
//
// Directed bench for wb_ram_slave. Two instances share the bus inputs:
// u_dut1 with one wait state and u_dut3 with three (used for the abort
// scenario). Inputs are driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_wb_ram_slave;

    logic        clk;
    logic        rst_i;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic        stb;
    logic        lock;
    logic        hold;

    logic [31:0] dat1, dat3;
    logic        ack1, err1, rty1;
    logic        ack3, err3, rty3;

    int checks;
    int failures;

    wb_ram_slave #(.WAIT_STATES(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst_i), .adr_i(adr), .dat_i(wdat), .dat_o(dat1),
        .sel_i(sel), .we_i(we), .cyc_i(cyc), .stb_i(stb), .lock_i(lock),
        .hold_i(hold), .ack_o(ack1), .err_o(err1), .rty_o(rty1)
    );

    wb_ram_slave #(.WAIT_STATES(3)) u_dut3 (
        .clk_i(clk), .rst_i(rst_i), .adr_i(adr), .dat_i(wdat), .dat_o(dat3),
        .sel_i(sel), .we_i(we), .cyc_i(cyc), .stb_i(stb), .lock_i(lock),
        .hold_i(hold), .ack_o(ack3), .err_o(err3), .rty_o(rty3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {ack, err, rty} of the selected instance
    function automatic logic [2:0] rsp(input bit on3);
        return on3 ? {ack3, err3, rty3} : {ack1, err1, rty1};
    endfunction

    // One bus transfer. lat counts falling edges after the request was driven
    // until a response is seen (0 = none within budget); after is the
    // response one cycle later, which must be idle.
    task automatic xfer(input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic w, input logic lk,
                        input logic hd, input bit on3,
                        output logic [2:0] resp, output int lat,
                        output logic [2:0] after);
        @(negedge clk);
        adr = a; wdat = d; sel = s; we = w; lock = lk; hold = hd;
        cyc = 1'b1; stb = 1'b1;
        resp = 3'b000;
        lat  = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (rsp(on3) != 3'b000) begin
                resp = rsp(on3);
                lat  = k;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; lock = 1'b0; hold = 1'b0; we = 1'b0;
        @(negedge clk);
        after = rsp(on3);
    endtask

    task automatic idle(input int n);
        cyc = 1'b0; stb = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_i = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({ack1, err1, rty1} !== 3'b000) begin
            failures++; $display("FAIL reset_resp got=%b exp=000", {ack1, err1, rty1});
        end
        checks++;
        if (dat1 !== 32'h0) begin
            failures++; $display("FAIL reset_dat1 got=%h exp=00000000", dat1);
        end
        checks++;
        if ({ack3, err3, rty3, dat3} !== 35'h0) begin
            failures++; $display("FAIL reset_dut3 got=%b/%h exp=000/0", {ack3, err3, rty3}, dat3);
        end
        rst_i = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [2:0] r, af;
        int lat;
        xfer(32'h10, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, r, lat, af);
        checks++;
        if (r !== 3'b100 || lat != 2) begin
            failures++; $display("FAIL basic_wr got=%b lat=%0d exp=100 lat=2", r, lat);
        end
        checks++;
        if (af !== 3'b000) begin
            failures++; $display("FAIL basic_wr_pulse got=%b exp=000", af);
        end
        xfer(32'h10, 32'h0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, r, lat, af);
        checks++;
        if (r !== 3'b100 || lat != 2 || af !== 3'b000) begin
            failures++; $display("FAIL basic_rd got=%b lat=%0d after=%b exp=100 lat=2 after=000", r, lat, af);
        end
        checks++;
        if (dat1 !== 32'hDEADBEEF) begin
            failures++; $display("FAIL basic_rd_data got=%h exp=deadbeef", dat1);
        end
    endtask

    task automatic test_byte_lanes();
        logic [2:0] r, af;
        int lat;
        xfer(32'h20, 32'h11223344, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, r, lat, af);
        xfer(32'h20, 32'hAABBCCDD, 4'b0101, 1'b1, 1'b0, 1'b0, 1'b0, r, lat, af);
        checks++;
        if (r !== 3'b100) begin
            failures++; $display("FAIL lanes_wr got=%b exp=100", r);
        end
        xfer(32'h20, 32'h0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, r, lat, af);
        checks++;
        if (dat1 !== 32'h11BB33DD) begin
            failures++; $display("FAIL lanes_rd got=%h exp=11bb33dd", dat1);
        end
        xfer(32'h20, 32'hFFFFFFFF, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, r, lat, af);
        checks++;
        if (r !== 3'b100) begin
            failures++; $display("FAIL lanes_sel0_ack got=%b exp=100", r);
        end
        xfer(32'h20, 32'h0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, r, lat, af);
        checks++;
        if (dat1 !== 32'h11BB33DD) begin
            failures++; $display("FAIL lanes_sel0_data got=%h exp=11bb33dd", dat1);
        end
    endtask

    task automatic test_errors();
        logic [2:0] r, af;
        int lat;
        // dat_o currently holds 11bb33dd from the previous read
        xfer(32'h0000_1000, 32'h0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, r, lat, af);
        checks++;
        if (r !== 3'b010 || lat != 2 || af !== 3'b000) begin
            failures++; $display("FAIL err_range got=%b lat=%0d after=%b exp=010 lat=2 after=000", r, lat, af);
        end
        checks++;
        if (dat1 !== 32'h11BB33DD) begin
            failures++; $display("FAIL err_range_dat got=%h exp=11bb33dd", dat1);
        end
        xfer(32'h0000_0002, 32'h0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, r, lat, af);
        checks++;
        if (r !== 3'b010 || dat1 !== 32'h11BB33DD) begin
            failures++; $display("FAIL err_align got=%b/%h exp=010/11bb33dd", r, dat1);
        end
        // Misaligned write into the word at 0x10 must not land
        xfer(32'h0000_0012, 32'h0, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, r, lat, af);
        checks++;
        if (r !== 3'b010) begin
            failures++; $display("FAIL err_align_wr got=%b exp=010", r);
        end
        xfer(32'h0000_1010, 32'h0, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, r, lat, af);
        checks++;
        if (r !== 3'b010) begin
            failures++; $display("FAIL err_range_wr got=%b exp=010", r);
        end
        xfer(32'h10, 32'h0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, r, lat, af);
        checks++;
        if (dat1 !== 32'hDEADBEEF) begin
            failures++; $display("FAIL err_no_write got=%h exp=deadbeef", dat1);
        end
    endtask

    task automatic test_retry_lock();
        logic [2:0] r, af;
        int lat;
        xfer(32'h30, 32'h55555555, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, r, lat, af);
        xfer(32'h30, 32'h12345678, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0, r, lat, af);
        checks++;
        if (r !== 3'b001 || lat != 2 || af !== 3'b000) begin
            failures++; $display("FAIL rty_wr got=%b lat=%0d after=%b exp=001 lat=2 after=000", r, lat, af);
        end
        xfer(32'h30, 32'h0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, r, lat, af);
        checks++;
        if (dat1 !== 32'h55555555) begin
            failures++; $display("FAIL rty_no_write got=%h exp=55555555", dat1);
        end
        xfer(32'h30, 32'h12345678, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0, r, lat, af);
        checks++;
        if (r !== 3'b100) begin
            failures++; $display("FAIL lock_wr got=%b exp=100", r);
        end
        // Unlocked read under hold: retry, dat_o keeps 55555555
        xfer(32'h30, 32'h0, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, r, lat, af);
        checks++;
        if (r !== 3'b001 || dat1 !== 32'h55555555) begin
            failures++; $display("FAIL rty_rd got=%b/%h exp=001/55555555", r, dat1);
        end
        xfer(32'h30, 32'h0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, r, lat, af);
        checks++;
        if (dat1 !== 32'h12345678) begin
            failures++; $display("FAIL lock_rd got=%h exp=12345678", dat1);
        end
    endtask

    task automatic test_back_to_back();
        int first1, second1, first3, second3;
        first1 = 0; second1 = 0; first3 = 0; second3 = 0;
        @(negedge clk);
        adr = 32'h10; wdat = 32'h0; sel = 4'hF; we = 1'b0; lock = 1'b0; hold = 1'b0;
        cyc = 1'b1; stb = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (ack1) begin
                if (first1 == 0) first1 = k;
                else if (second1 == 0) second1 = k;
            end
            if (ack3) begin
                if (first3 == 0) first3 = k;
                else if (second3 == 0) second3 = k;
            end
        end
        idle(2);
        checks++;
        if (first1 != 2 || second1 != 5) begin
            failures++; $display("FAIL b2b_ws1 got=%0d,%0d exp=2,5", first1, second1);
        end
        checks++;
        if (first3 != 4 || second3 != 9) begin
            failures++; $display("FAIL b2b_ws3 got=%0d,%0d exp=4,9", first3, second3);
        end
    endtask

    task automatic test_abort();
        logic [2:0] r, af;
        logic [2:0] seen;
        int lat;
        xfer(32'h40, 32'hCAFEF00D, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, r, lat, af);
        checks++;
        if (r !== 3'b100 || lat != 4 || af !== 3'b000) begin
            failures++; $display("FAIL ws3_wr got=%b lat=%0d after=%b exp=100 lat=4 after=000", r, lat, af);
        end
        idle(2);
        // Drop cyc one cycle after acceptance
        @(negedge clk);
        adr = 32'h40; wdat = 32'hBADBAD00; sel = 4'hF; we = 1'b1;
        cyc = 1'b1; stb = 1'b1;
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        seen = 3'b000;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            seen = seen | {ack3, err3, rty3};
        end
        checks++;
        if (seen !== 3'b000) begin
            failures++; $display("FAIL abort_no_resp got=%b exp=000", seen);
        end
        xfer(32'h40, 32'h0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1, r, lat, af);
        checks++;
        if (r !== 3'b100 || lat != 4) begin
            failures++; $display("FAIL abort_idle got=%b lat=%0d exp=100 lat=4", r, lat);
        end
        checks++;
        if (dat3 !== 32'hCAFEF00D) begin
            failures++; $display("FAIL abort_old_data got=%h exp=cafef00d", dat3);
        end
    endtask

    task automatic test_reset_mid();
        logic [2:0] r, af;
        int lat;
        // Write of zeros to 0x10, reset while waiting
        @(negedge clk);
        adr = 32'h10; wdat = 32'h0; sel = 4'hF; we = 1'b1;
        cyc = 1'b1; stb = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        #1;
        checks++;
        if ({ack1, err1, rty1} !== 3'b000 || dat1 !== 32'h0) begin
            failures++; $display("FAIL rst_wait got=%b/%h exp=000/00000000", {ack1, err1, rty1}, dat1);
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        rst_i = 1'b1;
        xfer(32'h10, 32'h0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, r, lat, af);
        checks++;
        if (r !== 3'b100 || dat1 !== 32'hDEADBEEF) begin
            failures++; $display("FAIL rst_keeps_ram got=%b/%h exp=100/deadbeef", r, dat1);
        end
        idle(2);
        // Reset during the response cycle of a read
        @(negedge clk);
        adr = 32'h20; sel = 4'hF; we = 1'b0; cyc = 1'b1; stb = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (ack1 !== 1'b1 || dat1 !== 32'h11BB33DD) begin
            failures++; $display("FAIL rst_resp_pre got=%b/%h exp=1/11bb33dd", ack1, dat1);
        end
        rst_i = 1'b0;
        #1;
        checks++;
        if (ack1 !== 1'b0 || dat1 !== 32'h0) begin
            failures++; $display("FAIL rst_resp_drop got=%b/%h exp=0/00000000", ack1, dat1);
        end
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_i = 1'b0;
        adr = '0; wdat = '0; sel = '0; we = 1'b0;
        cyc = 1'b0; stb = 1'b0; lock = 1'b0; hold = 1'b0;
        test_reset();
        test_basic();
        test_byte_lanes();
        test_errors();
        test_retry_lock();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_ram_slave.md
# wb_ram_slave

Wishbone classic single-port RAM slave that sits directly downstream of the single-stage `cpu` and terminates its bus cycles (adr/dat/sel/we/cyc/stb/lock in; ack/err/rty/dat out). It adds a programmable number of wait states, byte-lane writes, address-range and alignment checking, and a retry path driven by an external hold signal. It serves as the default instruction/data memory of the single-stage hardware build.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data bus width (fixed 32 in this block)
- SEL_WIDTH, 4, byte-select width (DATA_WIDTH/8)
- DEPTH_WORDS, 1024, RAM depth in 32-bit words (power of two)
- BASE_ADDR, 32'h0000_0000, byte address of word 0 (DEPTH_WORDS*4 aligned)
- WAIT_STATES, 1, extra cycles inserted before every response (0..15)

- clk_i  input  1  clock, all state on rising edge
- rst_i  input  1  reset, asynchronous, active-low
- adr_i  input  ADDR_WIDTH  byte address
- dat_i  input  DATA_WIDTH  write data
- dat_o  output  DATA_WIDTH  read data
- sel_i  input  SEL_WIDTH  byte enables, bit n = dat[8n+7:8n]
- we_i  input  1  1 = write, 0 = read
- cyc_i  input  1  bus cycle active
- stb_i  input  1  transfer strobe
- lock_i  input  1  locked sequence; suppresses retry
- hold_i  input  1  memory busy; forces rty_o when not locked
- ack_o  output  1  normal termination, one-cycle pulse
- err_o  output  1  error termination, one-cycle pulse
- rty_o  output  1  retry termination, one-cycle pulse

## Operation
- FSM: IDLE, WAIT, RESP.
- IDLE: on rising edge with cyc_i & stb_i = 1, latch adr_i, dat_i, sel_i, we_i, lock_i into request registers; load wait counter with WAIT_STATES; go to WAIT if WAIT_STATES>0, else evaluate and go to RESP.
- WAIT: decrement counter each edge; when counter reaches 1, evaluate and go to RESP. If cyc_i = 0 at any WAIT edge: abort, go to IDLE, no write, no response.
- Evaluation (edge entering RESP), priority order:
  - err: latched address outside [BASE_ADDR, BASE_ADDR+DEPTH_WORDS*4) or adr[1:0] != 0 -> err_o; no memory access.
  - rty: hold_i = 1 and latched lock = 0 -> rty_o; no memory access.
  - ack: word index = (adr-BASE_ADDR)>>2; write: update only bytes with sel bit set (sel = 0 writes nothing, still acks); read: dat_o <= RAM[index].
- RESP: exactly one of ack_o/err_o/rty_o high for one cycle; next edge returns to IDLE (may accept a new request at that edge's following IDLE cycle).
- Inputs changed after acceptance are ignored until return to IDLE.
- dat_o holds last read value; changes only on an acked read.
- RAM contents are not affected by reset.

## Timing
- Reset (rst_i low, async): state = IDLE, ack_o = err_o = rty_o = 0, dat_o = 0, counter = 0.
- Request presented in cycle c is accepted at the edge ending cycle c; response is high during cycle c+1+WAIT_STATES.
- Back-to-back: strobe held high after response is accepted at the edge ending the RESP cycle+1 (one idle cycle between transfers); throughput = 1 transfer per WAIT_STATES+2 cycles.
- Write takes effect at the RESP-entry edge; a read in the next transfer returns the new data.
- Reset asserted in WAIT or RESP: response dropped immediately, any not-yet-committed write is discarded.
- hold_i is sampled only at the RESP-entry edge.

## Test plan
- WAIT_STATES=1: write 32'hDEADBEEF to 0x10, sel=4'hF, then read 0x10 -> ack_o high in cycle c+2 each time, dat_o = 32'hDEADBEEF.
- Byte lanes: preload 0x20 with 32'h11223344, write 32'hAABBCCDD with sel=4'b0101 -> read returns 32'h11BB33DD; sel=4'b0000 write -> ack, data unchanged.
- Errors: read 0x0000_1000 (DEPTH_WORDS=1024) and read 0x0000_0002 -> err_o one-cycle pulse, ack_o = 0, dat_o unchanged, no write on write variants.
- Retry/lock: hold_i=1, lock_i=0 write to 0x30 -> rty_o, memory unchanged; same with lock_i=1 -> ack_o, data written.
- Abort: WAIT_STATES=3, drop cyc_i one cycle after acceptance -> no response pulse, FSM IDLE, subsequent read of target shows old data.
- Reset: pull rst_i low during WAIT -> all outputs 0 same cycle, dat_o=0; after release a read of previously written 0x10 still returns 32'hDEADBEEF.
